// File: rtl/i2c_line_filter.sv
// i2c_line_filter
//   Glitch filter for the synchronised I2C lines plus bus-condition detection.
//   Each line must hold a new level for FILT_LEN enabled cycles before the
//   filtered copy follows it. From the filtered lines it derives SCL edge
//   pulses, START/STOP pulses, a bus-busy flag and an optional SCL-low timeout.
//   Everything advances only on cycles where sync_clk_en is high.
//
// Parameters
//   FILT_LEN  enabled cycles a line must differ before its filtered value flips (3..255)
//   TOUT_CYC  enabled cycles of SCL low while busy before timeout; 0 disables (0..2^24-1)
//
// Ports
//   sync_clk     in   clock
//   sync_rst_n   in   asynchronous active-low reset
//   sync_clk_en  in   sample enable
//   scl_sync     in   synchronised SCL
//   sda_sync     in   synchronised SDA
//   scl_filt     out  filtered SCL
//   sda_filt     out  filtered SDA
//   scl_rise     out  one-cycle pulse on scl_filt 0->1
//   scl_fall     out  one-cycle pulse on scl_filt 1->0
//   start_det    out  one-cycle pulse on START / repeated START
//   stop_det     out  one-cycle pulse on STOP
//   bus_busy     out  high between START and STOP/timeout
//   bus_timeout  out  one-cycle pulse when the SCL-low limit is reached

module i2c_line_filter #(
  parameter int FILT_LEN = 4,
  parameter int TOUT_CYC = 0
) (
  input  logic sync_clk,
  input  logic sync_rst_n,
  input  logic sync_clk_en,
  input  logic scl_sync,
  input  logic sda_sync,
  output logic scl_filt,
  output logic sda_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic bus_timeout
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] FILT_MAX = CW'(FILT_LEN);
  localparam logic [23:0]   TOUT_V   = 24'(TOUT_CYC);

  logic          scl_filt_q, scl_filt_d;
  logic          sda_filt_q, sda_filt_d;
  logic [CW-1:0] scl_cnt_q, scl_cnt_d;
  logic [CW-1:0] sda_cnt_q, sda_cnt_d;
  logic          scl_rise_q, scl_rise_d;
  logic          scl_fall_q, scl_fall_d;
  logic          start_det_q, start_det_d;
  logic          stop_det_q, stop_det_d;
  logic          bus_busy_q, bus_busy_d;
  logic          bus_timeout_q, bus_timeout_d;
  logic [23:0]   tout_cnt_q, tout_cnt_d;

  logic [CW-1:0] scl_cnt_inc;
  logic [CW-1:0] sda_cnt_inc;
  logic [23:0]   tout_cnt_inc;

  always_comb begin
    scl_filt_d    = scl_filt_q;
    sda_filt_d    = sda_filt_q;
    scl_cnt_d     = scl_cnt_q;
    sda_cnt_d     = sda_cnt_q;
    bus_busy_d    = bus_busy_q;
    tout_cnt_d    = tout_cnt_q;
    scl_cnt_inc   = scl_cnt_q + 1'b1;
    sda_cnt_inc   = sda_cnt_q + 1'b1;
    tout_cnt_inc  = tout_cnt_q + 24'd1;
    // Pulses default low so they last one cycle and stay low while disabled.
    scl_rise_d    = 1'b0;
    scl_fall_d    = 1'b0;
    start_det_d   = 1'b0;
    stop_det_d    = 1'b0;
    bus_timeout_d = 1'b0;

    if (sync_clk_en) begin
      // Any sample agreeing with the filtered value restarts the count.
      if (scl_sync != scl_filt_q) begin
        if (scl_cnt_inc == FILT_MAX) begin
          scl_filt_d = scl_sync;
          scl_cnt_d  = '0;
        end else begin
          scl_cnt_d  = scl_cnt_inc;
        end
      end else begin
        scl_cnt_d = '0;
      end

      if (sda_sync != sda_filt_q) begin
        if (sda_cnt_inc == FILT_MAX) begin
          sda_filt_d = sda_sync;
          sda_cnt_d  = '0;
        end else begin
          sda_cnt_d  = sda_cnt_inc;
        end
      end else begin
        sda_cnt_d = '0;
      end

      scl_rise_d  = !scl_filt_q &&  scl_filt_d;
      scl_fall_d  =  scl_filt_q && !scl_filt_d;
      // SCL must be high both before and after the edge, so SDA flipping on
      // the same edge as SCL is never a START/STOP.
      start_det_d = scl_filt_q && scl_filt_d &&  sda_filt_q && !sda_filt_d;
      stop_det_d  = scl_filt_q && scl_filt_d && !sda_filt_q &&  sda_filt_d;

      if ((TOUT_V != 24'd0) && bus_busy_q && !scl_filt_q) begin
        if (tout_cnt_inc == TOUT_V) begin
          bus_timeout_d = 1'b1;
          tout_cnt_d    = '0;
        end else begin
          tout_cnt_d    = tout_cnt_inc;
        end
      end else begin
        tout_cnt_d = '0;
      end

      // START takes priority over a coincident timeout.
      if (start_det_d) begin
        bus_busy_d    = 1'b1;
        bus_timeout_d = 1'b0;
        tout_cnt_d    = '0;
      end else if (stop_det_d || bus_timeout_d) begin
        bus_busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sync_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      scl_filt_q    <= 1'b1;
      sda_filt_q    <= 1'b1;
      scl_cnt_q     <= '0;
      sda_cnt_q     <= '0;
      scl_rise_q    <= 1'b0;
      scl_fall_q    <= 1'b0;
      start_det_q   <= 1'b0;
      stop_det_q    <= 1'b0;
      bus_busy_q    <= 1'b0;
      bus_timeout_q <= 1'b0;
      tout_cnt_q    <= '0;
    end else begin
      scl_filt_q    <= scl_filt_d;
      sda_filt_q    <= sda_filt_d;
      scl_cnt_q     <= scl_cnt_d;
      sda_cnt_q     <= sda_cnt_d;
      scl_rise_q    <= scl_rise_d;
      scl_fall_q    <= scl_fall_d;
      start_det_q   <= start_det_d;
      stop_det_q    <= stop_det_d;
      bus_busy_q    <= bus_busy_d;
      bus_timeout_q <= bus_timeout_d;
      tout_cnt_q    <= tout_cnt_d;
    end
  end

  assign scl_filt    = scl_filt_q;
  assign sda_filt    = sda_filt_q;
  assign scl_rise    = scl_rise_q;
  assign scl_fall    = scl_fall_q;
  assign start_det   = start_det_q;
  assign stop_det    = stop_det_q;
  assign bus_busy    = bus_busy_q;
  assign bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_i2c_line_filter.sv
module tb_i2c_line_filter;

  localparam int FILT_LEN = 4;
  localparam int TOUT_CYC = 100;

  logic sync_clk = 1'b0;
  logic sync_rst_n = 1'b0;
  logic sync_clk_en = 1'b1;
  logic scl_sync = 1'b1;
  logic sda_sync = 1'b1;
  logic scl_filt, sda_filt, scl_rise, scl_fall, start_det, stop_det, bus_busy, bus_timeout;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  i2c_line_filter #(.FILT_LEN(FILT_LEN), .TOUT_CYC(TOUT_CYC)) dut (
    .sync_clk    (sync_clk),
    .sync_rst_n  (sync_rst_n),
    .sync_clk_en (sync_clk_en),
    .scl_sync    (scl_sync),
    .sda_sync    (sda_sync),
    .scl_filt    (scl_filt),
    .sda_filt    (sda_filt),
    .scl_rise    (scl_rise),
    .scl_fall    (scl_fall),
    .start_det   (start_det),
    .stop_det    (stop_det),
    .bus_busy    (bus_busy),
    .bus_timeout (bus_timeout)
  );

  always #5 sync_clk = ~sync_clk;

  logic [7:0] outs;
  assign outs = {scl_filt, sda_filt, scl_rise, scl_fall, start_det, stop_det, bus_busy, bus_timeout};

  // ---------------- reference model ----------------
  // A line's filtered value flips once the last FILT_LEN enabled samples all
  // disagree with it. Bus state follows the START/STOP/timeout rules.
  bit m_scl = 1'b1, m_sda = 1'b1, m_busy = 1'b0;
  bit m_rise = 1'b0, m_fall = 1'b0, m_start = 1'b0, m_stop = 1'b0, m_to = 1'b0;
  int m_low = 0;
  bit q_scl[$];
  bit q_sda[$];

  function automatic bit window_flips(input bit q[$], input bit cur);
    if (q.size() != FILT_LEN) return 1'b0;
    foreach (q[i]) if (q[i] == cur) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge sync_clk or negedge sync_rst_n) begin
    bit n_scl, n_sda, st, sp, to, busy;
    int low;
    if (!sync_rst_n) begin
      q_scl.delete();
      q_sda.delete();
      m_scl <= 1'b1; m_sda <= 1'b1; m_busy <= 1'b0; m_low <= 0;
      m_rise <= 1'b0; m_fall <= 1'b0; m_start <= 1'b0; m_stop <= 1'b0; m_to <= 1'b0;
    end else if (!sync_clk_en) begin
      m_rise <= 1'b0; m_fall <= 1'b0; m_start <= 1'b0; m_stop <= 1'b0; m_to <= 1'b0;
    end else begin
      q_scl.push_back(scl_sync);
      q_sda.push_back(sda_sync);
      if (q_scl.size() > FILT_LEN) void'(q_scl.pop_front());
      if (q_sda.size() > FILT_LEN) void'(q_sda.pop_front());
      n_scl = window_flips(q_scl, m_scl) ? !m_scl : m_scl;
      n_sda = window_flips(q_sda, m_sda) ? !m_sda : m_sda;
      st = m_scl && n_scl && m_sda && !n_sda;
      sp = m_scl && n_scl && !m_sda && n_sda;
      to = 1'b0;
      low = 0;
      if (TOUT_CYC != 0 && m_busy && !m_scl) begin
        low = m_low + 1;
        if (low == TOUT_CYC) begin
          to = 1'b1;
          low = 0;
        end
      end
      busy = m_busy;
      if (st) begin
        busy = 1'b1; to = 1'b0; low = 0;
      end else if (sp || to) begin
        busy = 1'b0;
      end
      m_rise <= !m_scl && n_scl;
      m_fall <= m_scl && !n_scl;
      m_start <= st; m_stop <= sp; m_to <= to;
      m_busy <= busy; m_low <= low;
      m_scl <= n_scl; m_sda <= n_sda;
    end
  end

  always @(negedge sync_clk) begin
    logic [7:0] exp_v;
    if (cmp_en) begin
      exp_v = {m_scl, m_sda, m_rise, m_fall, m_start, m_stop, m_busy, m_to};
      checks++;
      if (outs !== exp_v) begin
        failures++;
        $display("FAIL model_cmp t=%0t act=%b exp=%b (scl_f sda_f rise fall start stop busy tout)",
                 $time, outs, exp_v);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sync_clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s t=%0t act=%b exp=%b", nm, $time, act, exp_v);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog t=%0t act=running exp=finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // T1: reset with idle lines, then with lines reading 0 for 2 cycles.
    tick(3);
    cmp_en = 1'b1;
    sync_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t1_idle_hi", outs, 8'b1100_0000);
    end
    sync_rst_n = 1'b0;
    scl_sync = 1'b0; sda_sync = 1'b0;
    tick(3);
    sync_rst_n = 1'b1;
    tick(2);
    scl_sync = 1'b1; sda_sync = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t1_idle_lo2", outs, 8'b1100_0000);
    end

    // T2: short SDA glitches are absorbed.
    for (int n = 1; n <= 3; n++) begin
      sda_sync = 1'b0;
      for (int i = 0; i < n; i++) begin
        tick(1);
        chk("t2_glitch", {7'b0, sda_filt}, 8'd1);
      end
      sda_sync = 1'b1;
      tick(6);
      chk("t2_glitch_after", outs, 8'b1100_0000);
    end

    // T2/T3: 4-cycle low is a START, released high is a STOP.
    sda_sync = 1'b0;
    tick(3);
    chk("t2_3rd_edge", {7'b0, sda_filt}, 8'd1);
    tick(1);
    chk("t3_start", outs, 8'b1000_1010);
    tick(1);
    chk("t3_start_1cyc", outs, 8'b1000_0010);
    sda_sync = 1'b1;
    tick(3);
    chk("t3_pre_stop", outs, 8'b1000_0010);
    tick(1);
    chk("t3_stop", outs, 8'b1100_0100);
    tick(1);
    chk("t3_stop_1cyc", outs, 8'b1100_0000);

    // T4: repeated START, SDA moves under SCL low, same-edge flips.
    sda_sync = 1'b0; tick(4);
    chk("t4_start", outs, 8'b1000_1010);
    scl_sync = 1'b0; tick(4);
    chk("t4_scl_fall", outs, 8'b0001_0010);
    sda_sync = 1'b1; tick(4);
    chk("t4_sda_under_low", outs, 8'b0100_0010);
    scl_sync = 1'b1; tick(4);
    chk("t4_scl_rise", outs, 8'b1110_0010);
    sda_sync = 1'b0; tick(4);
    chk("t4_rep_start", outs, 8'b1000_1010);
    sda_sync = 1'b1; tick(4);
    chk("t4_stop", outs, 8'b1100_0100);
    scl_sync = 1'b0; sda_sync = 1'b0; tick(4);
    chk("t4_both_fall", outs, 8'b0001_0000);
    scl_sync = 1'b1; tick(4);
    chk("t4_rise_sda_lo", outs, 8'b1010_0000);
    sda_sync = 1'b1; tick(4);
    chk("t4_stop_idle", outs, 8'b1100_0100);

    // T5: SCL-low timeout and an SCL release one edge short of it.
    sda_sync = 1'b0; tick(4);
    scl_sync = 1'b0; tick(4);
    chk("t5_scl_low", outs, 8'b0001_0010);
    tick(99);
    chk("t5_edge99", outs, 8'b0000_0010);
    tick(1);
    chk("t5_timeout", outs, 8'b0000_0001);
    tick(1);
    chk("t5_timeout_1cyc", outs, 8'b0000_0000);
    tick(150);
    chk("t5_no_retrigger", outs, 8'b0000_0000);
    scl_sync = 1'b1; tick(4);
    sda_sync = 1'b1; tick(4);
    chk("t5_recover", outs, 8'b1100_0100);
    sda_sync = 1'b0; tick(4);
    scl_sync = 1'b0; tick(4);
    tick(95);
    scl_sync = 1'b1; tick(4);
    chk("t5_release_99", outs, 8'b1010_0010);
    tick(5);
    chk("t5_still_busy", outs, 8'b1000_0010);
    sda_sync = 1'b1; tick(4);
    chk("t5_stop", outs, 8'b1100_0100);
    tick(2);

    // T6: enable at half rate doubles latency; pulse stays one cycle.
    sda_sync = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sync_clk_en = (i % 2 == 0);
      tick(1);
      chk("t6_half_rate_hold", {7'b0, sda_filt}, 8'd1);
    end
    sync_clk_en = 1'b1; tick(1);
    chk("t6_half_rate_start", outs, 8'b1000_1010);
    sync_clk_en = 1'b0; tick(1);
    chk("t6_pulse_1cyc", outs, 8'b1000_0010);
    sync_clk_en = 1'b1;
    scl_sync = 1'b0; tick(4);
    chk("t6_busy_low", outs, 8'b0001_0010);
    tick(2);
    // Mid-cycle asynchronous reset while busy.
    #2;
    sync_rst_n = 1'b0;
    #1;
    chk("t6_async_rst", outs, 8'b1100_0000);
    tick(2);
    scl_sync = 1'b1; sda_sync = 1'b1;
    sync_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("t6_after_rst", outs, 8'b1100_0000);
    end

    // Random traffic against the model.
    for (int s = 0; s < 700; s++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        sync_clk_en = 1'b1;
        scl_sync = 1'b1; sda_sync = 1'b1; tick(6);
        sda_sync = 1'b0; tick(6);
        scl_sync = 1'b0; tick($urandom_range(90, 130));
      end else if (r == 4) begin
        #2;
        sync_rst_n = 1'b0;
        tick($urandom_range(1, 3));
        sync_rst_n = 1'b1;
      end else begin
        scl_sync = 1'($urandom_range(0, 1));
        sda_sync = 1'($urandom_range(0, 1));
        sync_clk_en = ($urandom_range(0, 9) != 0);
        tick($urandom_range(1, 8));
      end
    end
    sync_clk_en = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
